// File: rtl/isa_stream_buf.sv
// Instruction-load buffer: queues (data, addr) writes from the loader and replays
// them to the instruction memory write port, one word per cycle with stall.
module isa_stream_buf #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic                       clk_cpu,
  input  logic                       rst,
  input  logic                       in_wren,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       in_auto,
  output logic                       in_full,
  input  logic                       flush,
  input  logic                       out_stall,
  output logic                       isa_wren_o,
  output logic [DATA_W-1:0]          isa_data_o,
  output logic [ADDR_W-1:0]          isa_addr_o,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]  last_addr;

  logic               push_c;
  logic               drop_c;
  logic               pop_c;
  logic [ADDR_W-1:0]  wr_addr_c;
  logic [LVL_W-1:0]   level_nxt_c;
  entry_t             head_c;

  // Push/pop decisions are taken on the pre-edge level; flush overrides both.
  always_comb begin
    push_c      = in_wren & ~flush & (level < LVL_W'(DEPTH));
    drop_c      = in_wren & ~flush & (level == LVL_W'(DEPTH));
    pop_c       = (level != '0) & ~out_stall & ~flush;
    wr_addr_c   = in_auto ? (last_addr + ADDR_W'(ADDR_STEP)) : in_addr;
    head_c      = mem[rd_ptr];
    level_nxt_c = level;
    if (flush) begin
      level_nxt_c = '0;
    end else if (push_c && !pop_c) begin
      level_nxt_c = level + LVL_W'(1);
    end else if (pop_c && !push_c) begin
      level_nxt_c = level - LVL_W'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by pointers and level.
  always_ff @(posedge clk_cpu) begin
    if (push_c) begin
      mem[wr_ptr] <= '{addr: wr_addr_c, data: in_data};
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      in_full    <= 1'b0;
      last_addr  <= '0;
      overflow   <= 1'b0;
      isa_wren_o <= 1'b0;
      isa_data_o <= '0;
      isa_addr_o <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level   <= level_nxt_c;
      in_full <= (level_nxt_c == LVL_W'(DEPTH));
      if (push_c) last_addr <= wr_addr_c;
      // A dropped write wins over a same-cycle clear.
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
      isa_wren_o <= pop_c;
      isa_data_o <= pop_c ? head_c.data : '0;
      isa_addr_o <= pop_c ? head_c.addr : '0;
    end
  end

endmodule

// File: tb/tb_isa_stream_buf.sv
// Self-checking bench for isa_stream_buf: vector table plus hand-written corner
// sequences, with a queue scoreboard checking every write-port pulse.
module tb_isa_stream_buf;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

  logic              clk_cpu = 1'b0;
  logic              rst = 1'b1;
  logic              in_wren = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              in_auto = 1'b0;
  logic              in_full;
  logic              flush = 1'b0;
  logic              out_stall = 1'b0;
  logic              isa_wren_o;
  logic [DATA_W-1:0] isa_data_o;
  logic [ADDR_W-1:0] isa_addr_o;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  isa_stream_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ADDR_STEP(1)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .in_wren(in_wren), .in_data(in_data),
    .in_addr(in_addr), .in_auto(in_auto), .in_full(in_full), .flush(flush),
    .out_stall(out_stall), .isa_wren_o(isa_wren_o), .isa_data_o(isa_data_o),
    .isa_addr_o(isa_addr_o), .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_t;

  typedef struct {
    logic              wren;
    logic              use_auto;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_wren;
    logic [LVL_W-1:0]  exp_level;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[11];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulse_cnt = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic idle();
    in_wren = 1'b0; in_auto = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
  endtask

  // Every write-port pulse must match the oldest expected entry.
  always @(negedge clk_cpu) begin
    if (!rst && isa_wren_o) begin
      pulse_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 128'(isa_wren_o), 128'(0));
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("out_addr", 128'(isa_addr_o), 128'(e.addr));
        chk("out_data", isa_data_o, e.data);
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d;

    vt[0]  = '{1'b1, 1'b0, 16'h0010, 128'hAAAA_0001, 16'h0010, 1'b0, 4'd1};
    vt[1]  = '{1'b1, 1'b0, 16'h0020, 128'hBBBB_0002, 16'h0020, 1'b1, 4'd1};
    vt[2]  = '{1'b1, 1'b0, 16'h0030, 128'hCCCC_0003, 16'h0030, 1'b1, 4'd1};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 128'h0,         16'h0000, 1'b1, 4'd0};
    vt[4]  = '{1'b0, 1'b0, 16'h0000, 128'h0,         16'h0000, 1'b0, 4'd0};
    vt[5]  = '{1'b1, 1'b0, 16'hFFFE, 128'hD000_0005, 16'hFFFE, 1'b0, 4'd1};
    vt[6]  = '{1'b1, 1'b1, 16'h1234, 128'hD000_0006, 16'hFFFF, 1'b1, 4'd1};
    vt[7]  = '{1'b1, 1'b1, 16'h1234, 128'hD000_0007, 16'h0000, 1'b1, 4'd1};
    vt[8]  = '{1'b1, 1'b1, 16'h1234, 128'hD000_0008, 16'h0001, 1'b1, 4'd1};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 128'h0,         16'h0000, 1'b1, 4'd0};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 128'h0,         16'h0000, 1'b0, 4'd0};

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_wren", 128'(isa_wren_o), 128'(0));
    chk("rst_data", isa_data_o, 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_full", 128'(in_full), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));

    // Table: in-order replay and auto-address wrap
    for (int i = 0; i < 11; i++) begin
      in_wren = vt[i].wren; in_auto = vt[i].use_auto;
      in_addr = vt[i].addr; in_data = vt[i].data;
      if (vt[i].wren) sb_q.push_back('{addr: vt[i].exp_addr, data: vt[i].data});
      step();
      chk($sformatf("vec%0d_wren", i), 128'(isa_wren_o), 128'(vt[i].exp_wren));
      chk($sformatf("vec%0d_level", i), 128'(level), 128'(vt[i].exp_level));
    end
    idle();

    // Overflow: stall, write DEPTH+2; last write also tries clr_ovf
    out_stall = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      in_wren = 1'b1; in_auto = 1'b0; in_addr = ADDR_W'(16'h0400 + i); in_data = d;
      clr_ovf = (i == int'(DEPTH) + 1);
      if (i < int'(DEPTH)) sb_q.push_back('{addr: in_addr, data: d});
      step();
      if (i < int'(DEPTH)) begin
        chk("ovf_fill_level", 128'(level), 128'(i + 1));
        chk("ovf_fill_full", 128'(in_full), 128'(i == int'(DEPTH) - 1));
        chk("ovf_fill_ovf", 128'(overflow), 128'(0));
      end
    end
    idle();
    chk("ovf_full", 128'(in_full), 128'(1));
    chk("ovf_level", 128'(level), 128'(DEPTH));
    chk("ovf_set_beats_clr", 128'(overflow), 128'(1));
    chk("ovf_stalled_wren", 128'(isa_wren_o), 128'(0));
    step();
    pulse_cnt = 0;
    out_stall = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 3; i++) step();
    chk("ovf_drain_pulses", 128'(pulse_cnt), 128'(DEPTH));
    chk("ovf_drain_level", 128'(level), 128'(0));
    chk("ovf_drain_full", 128'(in_full), 128'(0));
    chk("ovf_sticky", 128'(overflow), 128'(1));
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 128'(overflow), 128'(0));

    // Continuous push/pop for 20 cycles
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      in_wren = 1'b1; in_auto = 1'b0; in_addr = ADDR_W'(16'h0800 + i); in_data = d;
      sb_q.push_back('{addr: in_addr, data: d});
      step();
      chk("stream_level", 128'(level), 128'(1));
    end
    idle();
    step(); step();
    chk("stream_pulses", 128'(pulse_cnt), 128'(20));
    chk("stream_level_end", 128'(level), 128'(0));

    // Flush with 5 queued and a same-cycle write; stall released so a pop would occur
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_wren = 1'b1; in_auto = 1'b0; in_addr = ADDR_W'(16'h0100 + i);
      in_data = 128'(32'hF100 + i);
      step();
    end
    chk("pre_flush_level", 128'(level), 128'(5));
    out_stall = 1'b0; flush = 1'b1; in_wren = 1'b1; in_addr = 16'h0999;
    pulse_cnt = 0;
    step();
    idle();
    chk("flush_level", 128'(level), 128'(0));
    chk("flush_wren", 128'(isa_wren_o), 128'(0));
    chk("flush_ovf", 128'(overflow), 128'(0));
    in_wren = 1'b1; in_auto = 1'b1; in_data = 128'hF1F1_0105;
    sb_q.push_back('{addr: 16'h0105, data: 128'hF1F1_0105});
    step();
    idle();
    step(); step();
    chk("post_flush_pulses", 128'(pulse_cnt), 128'(1));

    // Reset mid-drain with 4 queued; last_addr must restart at 0
    out_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      in_wren = 1'b1; in_auto = 1'b0; in_addr = ADDR_W'(16'h0200 + i); in_data = d;
      sb_q.push_back('{addr: in_addr, data: d});
      step();
    end
    idle();
    out_stall = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    pulse_cnt = 0;
    chk("midrst_wren", 128'(isa_wren_o), 128'(0));
    chk("midrst_data", isa_data_o, 128'(0));
    chk("midrst_addr", 128'(isa_addr_o), 128'(0));
    chk("midrst_level", 128'(level), 128'(0));
    chk("midrst_full", 128'(in_full), 128'(0));
    for (int i = 0; i < 4; i++) step();
    chk("midrst_no_pulses", 128'(pulse_cnt), 128'(0));
    in_wren = 1'b1; in_auto = 1'b1; in_data = 128'hABCD;
    sb_q.push_back('{addr: 16'h0001, data: 128'hABCD});
    step();
    idle();
    step(); step();
    chk("midrst_auto_pulses", 128'(pulse_cnt), 128'(1));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
